cache_switch_controller: RTL
============================

Name: cache_switch_controller

Overview:
- Sequences the OS-initiated cache switch raised by the cache-switch instruction (decode-stage switch_cache_w, carried to EX).
- Stalls the pipeline and lets in-flight instructions drain. Waits for both caches to go idle, then retargets instruction and data accesses to the requested cache bank and flushes IF/ID.
- Sits beside the hazard detection and flush logic. Its stall/flush outputs are ORed into hold_IF_reg / reset_IF_reg / reset_ID_reg.

Parameters:
NUM_CACHES, 4, number of selectable cache banks (2..8)
CACHE_ID_W, 2, width of bank index; must satisfy 2**CACHE_ID_W >= NUM_CACHES
DRAIN_CYCLES, 3, cycles to hold after acceptance so EX/MEM/WB retire (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
switch_req  input  1  EX-stage valid cache-switch instruction, level, sampled only in IDLE
switch_id  input  CACHE_ID_W  requested bank, taken from rs1 data low bits in EX
icache_busy  input  1  instruction cache has an outstanding miss/refill
dcache_busy  input  1  data cache has an outstanding miss/refill/writeback
stall_pipeline  output  1  hold PC, IF/ID and ID/EX while high
flush_if_id  output  1  one-cycle pulse: clear IF/ID and ID/EX
active_cache  output  CACHE_ID_W  bank currently selected for I and D accesses
switch_done  output  1  one-cycle pulse when a switch (or same-bank no-op) completes
switch_err  output  1  one-cycle pulse when switch_id >= NUM_CACHES
switch_count  output  16  number of completed real switches, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (reset==0, async): state=IDLE, active_cache=0, switch_count=0, all pulse outputs 0, stall_pipeline=0, internal drain counter=0, target register=0.
- States: IDLE, DRAIN, WAIT_MEM, SWITCH, RELEASE. All outputs are registered (Moore); pulses last exactly one cycle.
- IDLE:
  - switch_req=1 and switch_id >= NUM_CACHES: stay IDLE; switch_err=1 next cycle; no stall.
  - switch_req=1 and switch_id == active_cache: stay IDLE; switch_done=1 next cycle; count unchanged; no stall.
  - switch_req=1 otherwise: latch target=switch_id; load drain counter=DRAIN_CYCLES; go to DRAIN; stall_pipeline=1 from the next cycle.
- DRAIN: stall=1; counter decrements each cycle. At counter==1 (i.e. after DRAIN_CYCLES cycles in DRAIN) go to WAIT_MEM.
- WAIT_MEM: stall=1; stay while icache_busy|dcache_busy; go to SWITCH in the cycle after both are sampled low.
- SWITCH (exactly 1 cycle): stall=1. On exit, active_cache<=target and switch_count<=switch_count+1 (16-bit wrap). Go to RELEASE.
- RELEASE (exactly 1 cycle): stall=1, flush_if_id=1, switch_done=1. Go to IDLE; stall drops in the following cycle.
- Minimum acceptance-to-done latency: DRAIN_CYCLES+3 cycles. Each busy cycle in WAIT_MEM adds one.
- switch_req and switch_id are ignored outside IDLE; the pipeline is stalled, so the requester must hold or re-issue. switch_req held high across the return to IDLE is treated as a new request; EX must clear it because of the flush.
- active_cache changes only at SWITCH exit and never glitches mid-access, since both caches are idle by then.
- Busy dropping and rising again in consecutive WAIT_MEM cycles: the decision uses only the current sample.
- Reset asserted in any state: immediate return to IDLE, stall released, active_cache=0, pending target discarded.

Test Plan:
- Reset, then switch_req=1, switch_id=2 for one cycle, caches idle, DRAIN_CYCLES=3 -> stall high 6 cycles; flush_if_id and switch_done pulse together in the last stall cycle; active_cache=2; switch_count=1.
- Repeat with switch_id=2 while active_cache=2 -> no stall; switch_done pulses 1 cycle; count stays 1.
- switch_id=3 with NUM_CACHES=3 -> switch_err pulse; no stall; active_cache unchanged.
- Request to bank 1 with dcache_busy=1 for 5 cycles into WAIT_MEM -> stall extends by 5 cycles; active_cache updates only after busy drops; done latency=DRAIN_CYCLES+3+5.
- Drive reset low during WAIT_MEM -> stall_pipeline=0 and active_cache=0 immediately (async); after release, no done pulse and state IDLE.
- Preload 65535 switches (or force count) and do one more real switch -> switch_count wraps to 0.

Source files
------------

// File: rtl/cache_switch_controller_if.sv
// Cache-switch handshake bundle between the EX/cache side and the switch controller.
// The pipeline/cache side is the master; the controller is the slave.
interface cache_switch_controller_if #(
    parameter int CACHE_ID_W = 2
);
    logic                  switch_req;
    logic [CACHE_ID_W-1:0] switch_id;
    logic                  icache_busy;
    logic                  dcache_busy;
    logic                  stall_pipeline;
    logic                  flush_if_id;
    logic [CACHE_ID_W-1:0] active_cache;
    logic                  switch_done;
    logic                  switch_err;
    logic [15:0]           switch_count;

    modport master (
        output switch_req, switch_id, icache_busy, dcache_busy,
        input  stall_pipeline, flush_if_id, active_cache, switch_done, switch_err, switch_count
    );

    modport slave (
        input  switch_req, switch_id, icache_busy, dcache_busy,
        output stall_pipeline, flush_if_id, active_cache, switch_done, switch_err, switch_count
    );
endinterface

// File: rtl/cache_switch_controller.sv
// Cache bank switch sequencer: stall, drain in-flight work, wait for both caches
// to go idle, retarget the active bank, then flush IF/ID.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no switch in progress; request/ID sampled here only
// ST_DRAIN   | pipeline stalled, counting down so EX/MEM/WB can retire
// ST_WAIT_MEM| stalled until icache and dcache are both sampled idle
// ST_SWITCH  | one cycle; active bank and switch count update on exit
// ST_RELEASE | one cycle; flush IF/ID and report completion
module cache_switch_controller #(
    parameter int NUM_CACHES   = 4,
    parameter int CACHE_ID_W   = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    cache_switch_controller_if.slave csw
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WAIT_MEM,
        ST_SWITCH,
        ST_RELEASE
    } state_e;

    // One extra bit so the bank limit itself is representable.
    localparam logic [CACHE_ID_W:0] BANK_LIMIT = (CACHE_ID_W + 1)'(NUM_CACHES);
    localparam logic [3:0]          DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e                state_q, state_d;
    logic [3:0]            drain_q, drain_d;
    logic [CACHE_ID_W-1:0] target_q, target_d;
    logic [CACHE_ID_W-1:0] active_cache_q, active_cache_d;
    logic [15:0]           switch_count_q, switch_count_d;
    logic                  stall_pipeline_q, stall_pipeline_d;
    logic                  flush_if_id_q, flush_if_id_d;
    logic                  switch_done_q, switch_done_d;
    logic                  switch_err_q, switch_err_d;

    logic id_invalid;
    assign id_invalid = {1'b0, csw.switch_id} >= BANK_LIMIT;

    // Next-state and registered-output computation; outputs follow the next state.
    always_comb begin
        state_d          = state_q;
        drain_d          = drain_q;
        target_d         = target_q;
        active_cache_d   = active_cache_q;
        switch_count_d   = switch_count_q;
        switch_done_d    = 1'b0;
        switch_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (csw.switch_req) begin
                    if (id_invalid) begin
                        switch_err_d = 1'b1;
                    end else if (csw.switch_id == active_cache_q) begin
                        switch_done_d = 1'b1;
                    end else begin
                        target_d = csw.switch_id;
                        drain_d  = DRAIN_LOAD;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q == 4'd1) begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (!(csw.icache_busy || csw.dcache_busy)) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                active_cache_d = target_q;
                switch_count_d = switch_count_q + 16'd1;
                state_d        = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_pipeline_d = (state_d != ST_IDLE);
        flush_if_id_d    = (state_d == ST_RELEASE);
        if (state_d == ST_RELEASE) begin
            switch_done_d = 1'b1;
        end
    end

    // State and output registers; reset drops the stall and discards any pending target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            drain_q          <= 4'd0;
            target_q         <= '0;
            active_cache_q   <= '0;
            switch_count_q   <= 16'd0;
            stall_pipeline_q <= 1'b0;
            flush_if_id_q    <= 1'b0;
            switch_done_q    <= 1'b0;
            switch_err_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            drain_q          <= drain_d;
            target_q         <= target_d;
            active_cache_q   <= active_cache_d;
            switch_count_q   <= switch_count_d;
            stall_pipeline_q <= stall_pipeline_d;
            flush_if_id_q    <= flush_if_id_d;
            switch_done_q    <= switch_done_d;
            switch_err_q     <= switch_err_d;
        end
    end

    assign csw.stall_pipeline = stall_pipeline_q;
    assign csw.flush_if_id    = flush_if_id_q;
    assign csw.active_cache   = active_cache_q;
    assign csw.switch_done    = switch_done_q;
    assign csw.switch_err     = switch_err_q;
    assign csw.switch_count   = switch_count_q;

endmodule
